// File: rtl/video_scandoubler.sv
// Line-doubling scan converter: TV-rate pixels fill a two-bank line buffer that is
// read back at VGA rate, with optional scanline dimming and a TV passthrough mode.
module video_scandoubler (
    input  logic        clk,
    input  logic        rst,
    input  logic        c3,
    input  logic        f1,
    input  logic [9:0]  vga_cnt_in,
    input  logic [9:0]  vga_cnt_out,
    input  logic [14:0] pix_in,
    input  logic        tv_blank,
    input  logic        vga_blank,
    input  logic        vga_line,
    input  logic        vga_on,
    input  logic        scanlines,
    output logic [14:0] rgb_out,
    output logic        blank_out,
    output logic [1:0]  bank_valid
);

    localparam int unsigned PIX_W    = 15;
    localparam int unsigned IDX_W    = 9;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned LINE_LEN = 360;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_LEN - 1);
    localparam logic [PIX_W-1:0] DIM_MASK  = 15'h3DEF;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_data_q;

    logic [IDX_W-1:0] wr_idx_c;
    logic             wr_bank_c;
    logic             wr_en_c;

    logic             s1_en_q,    s1_en_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_dim_q,   s1_dim_d;
    logic             s1_blank_q, s1_blank_d;
    logic [PIX_W-1:0] pt_pix_q,   pt_pix_d;
    logic             pt_blank_q, pt_blank_d;
    logic [PIX_W-1:0] rgb_q,      rgb_d;
    logic             blank_q,    blank_d;
    logic [1:0]       valid_q,    valid_d;
    logic [1:0]       armed_q,    armed_d;
    logic [PIX_W-1:0] vga_pix_c;

    assign wr_idx_c  = vga_cnt_in[IDX_W-1:0];
    assign wr_bank_c = vga_cnt_in[IDX_W];
    assign wr_en_c   = c3 & ~rst & (wr_idx_c < IDX_W'(LINE_LEN));

    // Dual-port buffer; the registered read sees contents from before a same-edge write.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[vga_cnt_in] <= pix_in;
        end
        if (rst) begin
            rd_data_q <= '0;
        end else if (f1) begin
            rd_data_q <= mem[vga_cnt_out];
        end
    end

    always_comb begin
        s1_en_d    = f1;
        s1_valid_d = s1_valid_q;
        s1_dim_d   = s1_dim_q;
        s1_blank_d = s1_blank_q;
        pt_pix_d   = pix_in;
        pt_blank_d = tv_blank;
        rgb_d      = rgb_q;
        blank_d    = blank_q;
        valid_d    = valid_q;
        armed_d    = armed_q;
        vga_pix_c  = s1_valid_q ? rd_data_q : '0;

        if (s1_dim_q) begin
            vga_pix_c = (vga_pix_c >> 1) & DIM_MASK;
        end

        // Read-side sideband is captured alongside the buffer read address.
        if (f1) begin
            s1_valid_d = valid_q[vga_cnt_out[IDX_W]];
            s1_dim_d   = scanlines & vga_line;
            s1_blank_d = vga_blank;
        end

        if (vga_on) begin
            if (s1_en_q) begin
                blank_d = s1_blank_q;
                rgb_d   = s1_blank_q ? '0 : vga_pix_c;
            end
        end else begin
            blank_d = pt_blank_q;
            rgb_d   = pt_blank_q ? '0 : pt_pix_q;
        end

        // A bank only becomes valid after a write run that started at index 0.
        if (wr_en_c) begin
            if (wr_idx_c == '0) begin
                valid_d[wr_bank_c] = 1'b0;
                armed_d[wr_bank_c] = 1'b1;
            end else if ((wr_idx_c == LAST_IDX) && armed_q[wr_bank_c]) begin
                valid_d[wr_bank_c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_dim_q   <= 1'b0;
            s1_blank_q <= 1'b1;
            pt_pix_q   <= '0;
            pt_blank_q <= 1'b1;
            rgb_q      <= '0;
            blank_q    <= 1'b1;
            valid_q    <= '0;
            armed_q    <= '0;
        end else begin
            s1_en_q    <= s1_en_d;
            s1_valid_q <= s1_valid_d;
            s1_dim_q   <= s1_dim_d;
            s1_blank_q <= s1_blank_d;
            pt_pix_q   <= pt_pix_d;
            pt_blank_q <= pt_blank_d;
            rgb_q      <= rgb_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
            armed_q    <= armed_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign blank_out  = blank_q;
    assign bank_valid = valid_q;

endmodule

// File: doc/video_scandoubler.md
VIDEO_SCANDOUBLER -- requirements
Module: video_scandoubler

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: c3  in  1  TV pixel strobe (7 MHz phase); f1  in  1  VGA pixel strobe (14 MHz phase).
REQ-004 SHALL have ports: vga_cnt_in  in  10  write address {line parity, TV pixel index}; vga_cnt_out  in  10  read address {inverted parity, VGA pixel index}.
REQ-005 SHALL have ports: pix_in  in  15  TV-rate RGB555 pixel {R[14:10],G[9:5],B[4:0]}; tv_blank  in  1; vga_blank  in  1; vga_line  in  1  second VGA half-line.
REQ-006 SHALL have ports: vga_on  in  1  doubler enable; scanlines  in  1  dim enable.
REQ-007 SHALL have ports: rgb_out  out  15  output pixel; blank_out  out  1  output blank; bank_valid  out  2  per-bank line-complete flags.

Function
REQ-008 SHALL contain a 1024x15 line buffer split into bank 0 (addr[9]=0) and bank 1 (addr[9]=1), 360 usable entries per bank (index 0..359).
REQ-009 Write: on a clk edge with c3=1 and vga_cnt_in[8:0] < 360, SHALL store pix_in at vga_cnt_in; indices >= 360 SHALL NOT write.
REQ-010 Read: on a clk edge with f1=1 SHALL register vga_cnt_out; buffer data SHALL appear on rgb_out exactly 2 clk after that sampling edge (address reg + data reg).
REQ-011 Without f1, the read address register and rgb_out SHALL hold.
REQ-012 bank_valid[b] SHALL clear on a write to bank b index 0 and set on a write to bank b index 359.
REQ-013 Simultaneous read and write to the same address: the read SHALL return the old contents (read-before-write).
REQ-014 If bank_valid[vga_cnt_out[9]] = 0 at the read sampling edge, rgb_out SHALL be 15'h0000 for that pixel.
REQ-015 Scanline dimming: when scanlines=1 and vga_line (sampled with the read address) = 1, each 5-bit channel SHALL be shifted right by 1 (e.g. 15'h7FFF -> 15'h3DEF); otherwise data SHALL pass unmodified.
REQ-016 blank_out, when vga_on=1, SHALL equal vga_blank delayed through the same 2-stage f1-qualified pipeline as rgb_out.
REQ-017 When blank_out=1, rgb_out SHALL be 15'h0000.
REQ-018 Passthrough: when vga_on=0, rgb_out SHALL equal pix_in and blank_out SHALL equal tv_blank, both delayed 2 clk (unqualified by f1); the buffer SHALL continue to be written.
REQ-019 Changing vga_on SHALL take effect on the next clk; up to 2 output cycles of mixed-path data are permitted.
REQ-020 Writes while f1 and c3 coincide SHALL both complete in the same cycle (true dual-port access).

Reset
REQ-021 While rst=1: rgb_out=15'h0000, blank_out=1, bank_valid=2'b00, and both pipeline stages clear; buffer contents need not clear.
REQ-022 rst SHALL take priority over c3/f1 on the same edge; after deassertion the first full line SHALL be written before its bank reads non-zero.
REQ-023 Reset mid-line SHALL leave both banks invalid until each receives a complete index 0..359 write sequence.

Verification
REQ-024 Reset, then write bank 0 indices 0..359 with pix_in = index, then read bank 0 index 5 with f1 -> rgb_out = 15'd5 two clk later; bank_valid = 2'b01.
REQ-025 After reset, read bank 1 index 10 before any bank 1 write -> rgb_out = 15'h0000.
REQ-026 Write 15'h7FFF to bank 0 index 0..359, read with scanlines=1, vga_line=1 -> rgb_out = 15'h3DEF; with vga_line=0 -> 15'h7FFF.
REQ-027 Write with vga_cnt_in[8:0] = 360 and pix_in = 15'h1234, then read that address -> previous contents unchanged.
REQ-028 vga_on=0, pix_in = 15'h0ABC, tv_blank=0 -> rgb_out = 15'h0ABC and blank_out = 0 two clk later; tv_blank=1 -> rgb_out = 15'h0000, blank_out = 1.
REQ-029 Assert rst while bank 1 is half-written, deassert, write bank 1 indices 100..359 only -> bank_valid[1] stays 0 and reads return 15'h0000.
